// File: rtl/macs_result_reader.sv
// Captures one 32 x 32-bit MACs result row on a MACs_ready rising edge and
// streams it out one element per accepted handshake, index 0 first.
module macs_result_reader (
    input  logic          clk,
    input  logic          reader_reset_n,
    input  logic          reader_enable,
    input  logic          MACs_ready,
    input  logic [1023:0] dataC_in,
    input  logic          word_ready,
    output logic [31:0]   word_out,
    output logic          word_valid,
    output logic [4:0]    word_idx,
    output logic          word_last,
    output logic          reader_busy,
    output logic          overrun
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    logic          state_q;
    logic          state_d;
    logic [4:0]    idx_q;
    logic [4:0]    idx_d;
    logic          ready_q;
    logic          overrun_q;
    logic          overrun_d;
    logic [1023:0] buf_q;

    logic          capture_edge;
    logic          transfer;
    logic          final_xfer;
    logic          load;
    logic [9:0]    bit_base;

    assign capture_edge = MACs_ready & ~ready_q;
    assign transfer     = (state_q == ST_DRAIN) & word_ready;
    assign final_xfer   = transfer & (idx_q == 5'd31);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_edge && reader_enable) begin
                    load    = 1'b1;
                    idx_d   = 5'd0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_xfer) begin
                    idx_d = 5'd0;
                    // A new row arriving exactly as the old one finishes is
                    // chained straight into a fresh drain, not an overrun.
                    if (capture_edge && reader_enable) begin
                        load    = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (transfer) begin
                        idx_d = idx_q + 5'd1;
                    end
                    if (capture_edge) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reader_reset_n) begin
        if (!reader_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 5'd0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ready_q   <= MACs_ready;
            overrun_q <= overrun_d;
        end
    end

    // Row storage needs no reset: it is only observable while draining.
    always_ff @(posedge clk) begin
        if (load) begin
            buf_q <= dataC_in;
        end
    end

    assign bit_base    = {idx_q, 5'd0};
    assign word_valid  = (state_q == ST_DRAIN);
    assign word_out    = word_valid ? buf_q[bit_base +: 32] : 32'd0;
    assign word_idx    = idx_q;
    assign word_last   = word_valid & (idx_q == 5'd31);
    assign reader_busy = word_valid;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_macs_result_reader.sv
// Directed bench for macs_result_reader: capture, streaming, stalls,
// overrun, chained capture, enable gating and asynchronous reset.
module tb_macs_result_reader;

    logic          clk;
    logic          reader_reset_n;
    logic          reader_enable;
    logic          MACs_ready;
    logic [1023:0] dataC_in;
    logic          word_ready;
    logic [31:0]   word_out;
    logic          word_valid;
    logic [4:0]    word_idx;
    logic          word_last;
    logic          reader_busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    macs_result_reader dut (
        .clk            (clk),
        .reader_reset_n (reader_reset_n),
        .reader_enable  (reader_enable),
        .MACs_ready     (MACs_ready),
        .dataC_in       (dataC_in),
        .word_ready     (word_ready),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_idx       (word_idx),
        .word_last      (word_last),
        .reader_busy    (reader_busy),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1023:0] make_row(input logic [31:0] base, input logic [31:0] stride);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[32*k +: 32] = base + stride * k;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise MACs_ready for one edge with the given row, leaving the DUT one
    // cycle after the capturing edge.
    task automatic pulse_capture(input logic [1023:0] row);
        dataC_in   = row;
        MACs_ready = 1'b1;
        step();
        MACs_ready = 1'b0;
    endtask

    task automatic test_reset();
        reader_reset_n = 1'b0;
        reader_enable  = 1'b0;
        MACs_ready     = 1'b0;
        word_ready     = 1'b0;
        dataC_in       = '0;
        step();
        step();
        checks++;
        if ({word_out, word_valid, word_idx, word_last, reader_busy, overrun} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h v=%b idx=%0d last=%b busy=%b ovr=%b, want all 0",
                     word_out, word_valid, word_idx, word_last, reader_busy, overrun);
        end
        reader_reset_n = 1'b1;
        reader_enable  = 1'b1;
        step();
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: word_valid=%b want 0", word_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        word_ready = 1'b1;
        pulse_capture(make_row(32'h2, 32'h0));
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (word_valid !== 1'b1 || reader_busy !== 1'b1 || word_out !== 32'h2 ||
                word_idx !== 5'(k) || word_last !== (k == 31)) begin
                errors++;
                $display("FAIL stream_word%0d: got v=%b busy=%b out=%h idx=%0d last=%b, want v=1 busy=1 out=00000002 idx=%0d last=%b",
                         k, word_valid, reader_busy, word_out, word_idx, word_last, k, (k == 31));
            end
            step();
        end
        checks++;
        if (word_valid !== 1'b0 || reader_busy !== 1'b0 || word_out !== 32'h0) begin
            errors++;
            $display("FAIL stream_end: got v=%b busy=%b out=%h, want 0 0 0", word_valid, reader_busy, word_out);
        end
        $display("test_stream: 32 words of 00000002");
    endtask

    task automatic test_stall();
        int k;
        int xfers;
        k     = 0;
        xfers = 0;
        word_ready = 1'b1;
        pulse_capture(make_row(32'h100, 32'h1));
        for (int cyc = 0; cyc < 200 && xfers < 32; cyc++) begin
            word_ready = (cyc % 2 == 0);
            checks++;
            if (word_valid !== 1'b1 || word_out !== 32'h100 + 32'(k) || word_idx !== 5'(k)) begin
                errors++;
                $display("FAIL stall_cyc%0d: got v=%b out=%h idx=%0d, want v=1 out=%h idx=%0d",
                         cyc, word_valid, word_out, word_idx, 32'h100 + 32'(k), k);
            end
            step();
            if (word_ready) begin
                k++;
                xfers++;
            end
        end
        word_ready = 1'b1;
        checks++;
        if (xfers !== 32 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got xfers=%0d v=%b, want 32 and v=0", xfers, word_valid);
        end
        $display("test_stall: %0d transfers with alternating ready", xfers);
    endtask

    task automatic test_hold();
        int valid_cycles;
        int starts;
        valid_cycles = 0;
        starts       = 0;
        word_ready   = 1'b1;
        dataC_in     = make_row(32'h300, 32'h1);
        MACs_ready   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (word_valid) valid_cycles++;
            if (word_valid && word_idx == 5'd0) starts++;
        end
        MACs_ready = 1'b0;
        checks++;
        if (valid_cycles !== 32 || starts !== 1) begin
            errors++;
            $display("FAIL hold_single_drain: got valid_cycles=%0d starts=%0d, want 32 and 1", valid_cycles, starts);
        end
        step();
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got v=%b ovr=%b, want 0 0", word_valid, overrun);
        end
        $display("test_hold: %0d valid cycles", valid_cycles);
    endtask

    task automatic test_enable_gate();
        reader_enable = 1'b0;
        pulse_capture(make_row(32'h400, 32'h1));
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL gate_disabled: got v=%b ovr=%b, want 0 0", word_valid, overrun);
        end
        MACs_ready = 1'b1;
        step();
        reader_enable = 1'b1;
        step();
        step();
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL gate_level_high: got v=%b, want 0", word_valid);
        end
        MACs_ready = 1'b0;
        step();
        $display("test_enable_gate done");
    endtask

    task automatic test_overrun();
        logic [1023:0] row_b;
        row_b      = make_row(32'hB000, 32'h1);
        word_ready = 1'b1;
        pulse_capture(make_row(32'hA000, 32'h1));
        for (int k = 0; k < 32; k++) begin
            // Drop reader_enable mid-drain: must not stop the stream.
            if (k == 5) reader_enable = 1'b0;
            if (k == 8) reader_enable = 1'b1;
            if (k == 10) begin
                dataC_in   = row_b;
                MACs_ready = 1'b1;
            end
            if (k == 11) MACs_ready = 1'b0;
            checks++;
            if (word_valid !== 1'b1 || word_out !== 32'hA000 + 32'(k) || word_idx !== 5'(k)) begin
                errors++;
                $display("FAIL overrun_word%0d: got v=%b out=%h idx=%0d, want v=1 out=%h idx=%0d",
                         k, word_valid, word_out, word_idx, 32'hA000 + 32'(k), k);
            end
            step();
        end
        checks++;
        if (overrun !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_flag: got ovr=%b v=%b, want 1 0", overrun, word_valid);
        end
        $display("test_overrun: overrun=%b", overrun);
    endtask

    task automatic test_midreset();
        word_ready = 1'b1;
        pulse_capture(make_row(32'h500, 32'h1));
        for (int k = 0; k < 15; k++) step();
        checks++;
        if (word_idx !== 5'd15 || word_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got idx=%0d v=%b, want 15 1", word_idx, word_valid);
        end
        #2;
        reader_reset_n = 1'b0;
        #1;
        checks++;
        if ({word_out, word_valid, word_idx, word_last, reader_busy, overrun} !== 41'd0) begin
            errors++;
            $display("FAIL midreset_async: got out=%h v=%b idx=%0d last=%b busy=%b ovr=%b, want all 0",
                     word_out, word_valid, word_idx, word_last, reader_busy, overrun);
        end
        #2;
        reader_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_words: got v=%b ovr=%b, want 0 0", word_valid, overrun);
        end
        pulse_capture(make_row(32'h600, 32'h1));
        checks++;
        if (word_valid !== 1'b1 || word_out !== 32'h600 || word_idx !== 5'd0) begin
            errors++;
            $display("FAIL midreset_recapture: got v=%b out=%h idx=%0d, want 1 00000600 0", word_valid, word_out, word_idx);
        end
        for (int k = 0; k < 32; k++) step();
        $display("test_midreset done");
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b1;
        pulse_capture(make_row(32'hC000, 32'h1));
        for (int k = 0; k < 31; k++) step();
        checks++;
        if (word_idx !== 5'd31 || word_last !== 1'b1 || word_out !== 32'hC01F) begin
            errors++;
            $display("FAIL b2b_last: got idx=%0d last=%b out=%h, want 31 1 0000c01f", word_idx, word_last, word_out);
        end
        pulse_capture(make_row(32'hD000, 32'h1));
        checks++;
        if (word_valid !== 1'b1 || word_idx !== 5'd0 || word_out !== 32'hD000 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_chain: got v=%b idx=%0d out=%h ovr=%b, want 1 0 0000d000 0",
                     word_valid, word_idx, word_out, overrun);
        end
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (word_out !== 32'hD000 + 32'(k) || word_idx !== 5'(k)) begin
                errors++;
                $display("FAIL b2b_word%0d: got out=%h idx=%0d, want %h %0d", k, word_out, word_idx, 32'hD000 + 32'(k), k);
            end
            step();
        end
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b ovr=%b, want 0 0", word_valid, overrun);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_hold();
        test_enable_gate();
        test_overrun();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
